// File: rtl/axis_divider.sv
// Iterative restoring unsigned divider with valid/ready handshakes on both sides,
// optional round-to-nearest, divide-by-zero flag and a tag carried to the result.
module axis_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 13,
  parameter int TAG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DIVIDEND_W-1:0] s_dividend,
  input  logic [DIVISOR_W-1:0]  s_divisor,
  input  logic                  s_round,
  input  logic [TAG_W-1:0]      s_tag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DIVIDEND_W-1:0] m_quotient,
  output logic [DIVISOR_W-1:0]  m_remainder,
  output logic                  m_dbz,
  output logic [TAG_W-1:0]      m_tag
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dq;       // dividend shifts out of the top, quotient shifts in at the bottom
  logic [DIVISOR_W-1:0]  prem;
  logic [DIVISOR_W-1:0]  div_r;
  logic                  rnd_r;
  logic                  dbz_r;
  logic [TAG_W-1:0]      tag_r;

  logic                  accept;
  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  prem_nxt;
  logic [DIVISOR_W+1:0]  twice_rem;
  logic                  round_up;

  assign accept    = s_valid && s_ready;
  assign shifted   = {prem, dq[DIVIDEND_W-1]};
  assign ge        = shifted >= {1'b0, div_r};
  assign prem_nxt  = ge ? DIVISOR_W'(shifted - {1'b0, div_r}) : shifted[DIVISOR_W-1:0];
  assign twice_rem = {1'b0, prem, 1'b0};
  assign round_up  = rnd_r && !dbz_r && (twice_rem >= {2'b00, div_r});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A zero divisor skips CALC and spends its one cycle in FIX so the
  // result appears one edge after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (s_divisor == '0) ? FIX : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      s_ready <= (state_nxt == IDLE);
      m_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      dq          <= '0;
      prem        <= '0;
      div_r       <= '0;
      rnd_r       <= 1'b0;
      dbz_r       <= 1'b0;
      tag_r       <= '0;
      m_quotient  <= '0;
      m_remainder <= '0;
      m_dbz       <= 1'b0;
      m_tag       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= CNT_W'(DIVIDEND_W - 1);
          prem  <= '0;
          div_r <= s_divisor;
          rnd_r <= s_round;
          tag_r <= s_tag;
          dbz_r <= (s_divisor == '0);
          dq    <= (s_divisor == '0) ? '1 : s_dividend;
        end
        CALC: begin
          prem <= prem_nxt;
          dq   <= {dq[DIVIDEND_W-2:0], ge};
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          m_quotient  <= dq + DIVIDEND_W'(round_up);
          m_remainder <= prem;
          m_dbz       <= dbz_r;
          m_tag       <= tag_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_divider.sv
// Self-checking bench for axis_divider: directed table, hand-built corner sequences
// and random operations checked against an arithmetic reference model.
module tb_axis_divider;

  localparam int DW = 32;
  localparam int VW = 13;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_dividend = '0;
  logic [VW-1:0] s_divisor = '0;
  logic          s_round = 1'b0;
  logic [TW-1:0] s_tag = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_quotient;
  logic [VW-1:0] m_remainder;
  logic          m_dbz;
  logic [TW-1:0] m_tag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_dividend(s_dividend), .s_divisor(s_divisor), .s_round(s_round), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_quotient(m_quotient), .m_remainder(m_remainder), .m_dbz(m_dbz), .m_tag(m_tag)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    bit            rnd;
    logic [TW-1:0] tag;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    bit            dbz;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, rounding applied to the quotient only.
  function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit rnd,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output bit dbz, output int lat);
    longint unsigned qq, rr;
    if (b == 0) begin
      q = '1; r = '0; dbz = 1'b1; lat = 1;
    end else begin
      qq = longint'(a) / longint'(b);
      rr = longint'(a) % longint'(b);
      if (rnd && (2 * rr >= longint'(b))) qq++;
      q = DW'(qq); r = VW'(rr); dbz = 1'b0; lat = DW + 1;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit rnd,
                      input logic [TW-1:0] tag, input bit keep);
    int n;
    s_valid = 1'b1; s_dividend = a; s_divisor = b; s_round = rnd; s_tag = tag;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (!s_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input string name);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk); lat++;
    end while (!m_valid && lat < 100);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_out(input logic [DW-1:0] q, input logic [VW-1:0] r, input bit dbz,
                           input logic [TW-1:0] tag, input string name);
    chk({name, "_valid"}, m_valid, 1);
    chk({name, "_q"}, m_quotient, q);
    chk({name, "_r"}, m_remainder, r);
    chk({name, "_dbz"}, m_dbz, dbz);
    chk({name, "_tag"}, m_tag, tag);
  endtask

  task automatic handshake(input string name);
    m_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    m_ready = 1'b0;
    chk({name, "_valid_drop"}, m_valid, 0);
    chk({name, "_ready_rise"}, s_ready, 1);
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit rnd,
                        input logic [TW-1:0] tag, input string name);
    logic [DW-1:0] q; logic [VW-1:0] r; bit dbz; int lat;
    model(a, b, rnd, q, r, dbz, lat);
    send(a, b, rnd, tag, 1'b0);
    wait_result(lat, name);
    check_out(q, r, dbz, tag, name);
    handshake(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q2; logic [VW-1:0] r2; bit dbz2; int lat2;
    logic [DW-1:0] ra; logic [VW-1:0] rb;
    int seen;

    tbl[0] = '{32'd16711680, 13'd4096, 1'b0, 8'h5A, 32'd4080, 13'd0, 1'b0};
    tbl[1] = '{32'd1000, 13'd7, 1'b0, 8'h01, 32'd142, 13'd6, 1'b0};
    tbl[2] = '{32'd1000, 13'd7, 1'b1, 8'h02, 32'd143, 13'd6, 1'b0};
    tbl[3] = '{32'd5, 13'd10, 1'b1, 8'h03, 32'd1, 13'd5, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 13'd1, 1'b1, 8'h04, 32'hFFFF_FFFF, 13'd0, 1'b0};
    tbl[5] = '{32'd0, 13'd4096, 1'b0, 8'h05, 32'd0, 13'd0, 1'b0};
    tbl[6] = '{32'd1234, 13'd0, 1'b0, 8'h06, 32'hFFFF_FFFF, 13'd0, 1'b1};
    tbl[7] = '{32'd1234, 13'd2, 1'b0, 8'h07, 32'd617, 13'd0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_outputs", {m_quotient, m_remainder, m_dbz, m_tag}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_s_ready", s_ready, 1);

    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].b, tbl[i].rnd, tbl[i].tag, 1'b0);
      wait_result(tbl[i].dbz ? 1 : DW + 1, $sformatf("tbl%0d", i));
      check_out(tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].tag, $sformatf("tbl%0d", i));
      handshake($sformatf("tbl%0d", i));
    end

    // Back-pressure with a second request already waiting on s_valid.
    send(32'd50000, 13'd300, 1'b1, 8'hA1, 1'b1);
    s_dividend = 32'd77777; s_divisor = 13'd123; s_round = 1'b0; s_tag = 8'hB2;
    wait_result(DW + 1, "bp1");
    model(32'd50000, 13'd300, 1'b1, q2, r2, dbz2, lat2);
    for (int c = 0; c < 10; c++) begin
      check_out(q2, r2, 1'b0, 8'hA1, "bp_hold");
      chk("bp_s_ready_low", s_ready, 0);
      @(negedge clk);
    end
    handshake("bp1");
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    chk("bp2_accepted", s_ready, 0);
    model(32'd77777, 13'd123, 1'b0, q2, r2, dbz2, lat2);
    wait_result(DW + 1, "bp2");
    check_out(q2, r2, 1'b0, 8'hB2, "bp2");
    handshake("bp2");

    // Reset in the middle of CALC discards the operation.
    send(32'd99999, 13'd17, 1'b0, 8'hCC, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_outputs", {m_quotient, m_remainder, m_dbz, m_tag}, 0);
    @(negedge clk);
    chk("midrst_s_ready", s_ready, 1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_valid) seen = 1;
      @(negedge clk);
    end
    chk("midrst_no_result", seen, 0);
    run_op(32'd100, 13'd3, 1'b0, 8'h33, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if (i % 4 == 0) ra = ra >> $urandom_range(0, 31);
      rb = VW'($urandom_range(0, 8191));
      if (i % 9 == 0) rb = '0;
      else if (i % 7 == 0) rb = VW'($urandom_range(1, 4));
      run_op(ra, rb, 1'($urandom_range(0, 1)), TW'($urandom), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
